dsp_result_reader: RTL

DSP_RESULT_READER -- requirements
Module: dsp_result_reader

---
 rtl/dsp_result_reader.sv | 66 ++++++
 1 files changed

// File: rtl/dsp_result_reader.sv
// dsp_result_reader: tracks DSP issues through a CE-gated delay line and buffers results in order in a small FIFO.
module dsp_result_reader #(
  parameter int DATA_W  = 48,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CE,
  input  logic                     issue_in,
  output logic                     issue_ready,
  input  logic [DATA_W-1:0]        P_in,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_data,
  input  logic                     res_ready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [LATENCY-1:0] dl_q, dl_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]        cnt_q, cnt_d, out_q, out_d;
  logic               ovf_q, ovf_d;
  logic               accept, dl_out, push, pop, wr;
  assign dl_out      = dl_q[LATENCY-1];
  assign issue_ready = out_q < FULL;
  assign res_valid   = cnt_q != '0;
  assign res_data    = res_valid ? mem_q[rp_q] : '0;
  assign outstanding = out_q;
  assign overflow    = ovf_q;
  always_comb begin
    accept = issue_in & issue_ready & CE;
    push   = dl_out & CE;
    pop    = res_valid & res_ready;
    wr     = push & ((cnt_q != FULL) | pop);
    dl_d   = CE ? ((dl_q << 1) | LATENCY'(accept)) : dl_q;
    wp_d   = wp_q + AW'(wr);
    rp_d   = rp_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    out_d  = out_q + (AW+1)'(accept) - (AW+1)'(pop);
    ovf_d  = ovf_q | (push & ~wr);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      dl_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      dl_q  <= dl_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end
  // storage is never cleared; res_data is masked to zero while empty
  always_ff @(posedge CLK) begin
    if (!RST && wr) mem_q[wp_q] <= P_in;
  end
endmodule
